// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle controller for an external single-position shifter stage.
// An accepted request latches the operand, the opcode and the shift amount.
// The block then drives the shifter once per cycle. On each cycle the
// shifter's Y output becomes the next A input, until the requested amount
// has been shifted.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request; sampled on a rising edge while not busy
//   op         {LA,LR}: 00/10 = SLL, 01 = SRL, 11 = SRA
//   a_in       operand
//   shamt      shift amount (0 .. 2^SHAMT_W-1)
//   busy       high while shifting
//   done       one-cycle completion pulse
//   result     final shifted word; held until the next accepted request
//   carry_out  last bit shifted out (0 when shamt = 0)
//   sh_a       shifter A input (working register)
//   sh_la      shifter LA input (latched op[1])
//   sh_lr      shifter LR input (latched op[0])
//   sh_y       shifter Y output (combinational from sh_a/sh_la/sh_lr)
//   sh_c       shifter C output (combinational from sh_a/sh_la/sh_lr)
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out,
    output logic [WIDTH-1:0]   sh_a,
    output logic               sh_la,
    output logic               sh_lr,
    input  logic [WIDTH-1:0]   sh_y,
    input  logic               sh_c
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [SHAMT_W-1:0] COUNT_ZERO = '0;
    localparam logic [SHAMT_W-1:0] COUNT_ONE  = SHAMT_W'(1);

    state_t             state_r;
    state_t             next_state_s;
    logic               accept_s;
    logic               last_step_s;

    logic [WIDTH-1:0]   work_r;
    logic [SHAMT_W-1:0] count_r;
    logic [WIDTH-1:0]   result_r;
    logic               carry_r;
    logic               la_r;
    logic               lr_r;
    logic               busy_r;
    logic               done_r;

    // Request acceptance and last-step detection.
    always_comb begin
        accept_s    = 1'b0;
        last_step_s = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
        // The count reaching one marks the final shifter pass, so the
        // decrement never wraps below zero.
        if ((state_r == ST_SHIFT) && (count_r == COUNT_ONE)) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                // An accept in DONE chains straight into the next
                // operation without visiting IDLE.
                if (accept_s) begin
                    if (shamt == COUNT_ZERO) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_SHIFT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_step_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_SHIFT);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Working register, opcode latch, step counter and result/carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r   <= '0;
            count_r  <= '0;
            result_r <= '0;
            carry_r  <= 1'b0;
            la_r     <= 1'b0;
            lr_r     <= 1'b0;
        end else if (accept_s) begin
            work_r  <= a_in;
            count_r <= shamt;
            carry_r <= 1'b0;
            la_r    <= op[1];
            lr_r    <= op[0];
            // A zero-length shift completes immediately with the operand.
            if (shamt == COUNT_ZERO) begin
                result_r <= a_in;
            end else begin
                result_r <= result_r;
            end
        end else if (state_r == ST_SHIFT) begin
            work_r  <= sh_y;
            count_r <= count_r - COUNT_ONE;
            carry_r <= sh_c;
            la_r    <= la_r;
            lr_r    <= lr_r;
            if (last_step_s) begin
                result_r <= sh_y;
            end else begin
                result_r <= result_r;
            end
        end else begin
            work_r   <= work_r;
            count_r  <= count_r;
            result_r <= result_r;
            carry_r  <= carry_r;
            la_r     <= la_r;
            lr_r     <= lr_r;
        end
    end

    // Every output comes directly from a register.
    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign carry_out = carry_r;
    assign sh_a      = work_r;
    assign sh_la     = la_r;
    assign sh_lr     = lr_r;

endmodule
